// File: rtl/reset_sequencer.sv
// Post-reset sequencer: qualifies a synchronised PLL lock, then releases per-subsystem
// active-low resets one at a time with a fixed gap; any lock loss re-asserts them all.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES         = 3,
    parameter int unsigned STAGE_DELAY        = 255,
    parameter int unsigned LOCK_STABLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_locked,
    output logic [NUM_STAGES-1:0] stage_resetn,
    output logic                  seq_done,
    output logic                  lock_lost
);

    localparam int unsigned DLY_W = $clog2(STAGE_DELAY + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned K_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_DONE      = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  sync1_q;
    logic                  lock_s_q;
    logic [STB_W-1:0]      stable_q, stable_d;
    logic [DLY_W-1:0]      dly_q, dly_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic                  lost_q, lost_d;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_WAIT_LOCK;
            stable_q <= '0;
            dly_q    <= '0;
            k_q      <= '0;
            stage_q  <= '0;
            done_q   <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            dly_q    <= dly_d;
            k_q      <= k_d;
            stage_q  <= stage_d;
            done_q   <= done_d;
            lost_q   <= lost_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        dly_d    = dly_q;
        k_d      = k_q;
        stage_d  = stage_q;
        done_d   = done_q;
        lost_d   = 1'b0;

        // Lock loss after qualification wins over any release due on the same edge
        if ((state_q != ST_WAIT_LOCK) && !lock_s_q) begin
            state_d  = ST_WAIT_LOCK;
            stable_d = '0;
            dly_d    = '0;
            k_d      = '0;
            stage_d  = '0;
            done_d   = 1'b0;
            lost_d   = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (!lock_s_q) begin
                        stable_d = '0;
                    end else if (stable_q >= STB_W'(LOCK_STABLE_CYCLES - 1)) begin
                        stable_d = STB_W'(LOCK_STABLE_CYCLES);
                        dly_d    = '0;
                        k_d      = '0;
                        state_d  = ST_RELEASE;
                    end else begin
                        stable_d = stable_q + STB_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (dly_q >= DLY_W'(STAGE_DELAY)) begin
                        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                            if (k_q == K_W'(i)) begin
                                stage_d[i] = 1'b1;
                            end
                        end
                        dly_d = '0;
                        if (k_q == K_W'(NUM_STAGES - 1)) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            k_d = k_q + K_W'(1);
                        end
                    end else begin
                        dly_d = dly_q + DLY_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                end
            endcase
        end
    end

    assign stage_resetn = stage_q;
    assign seq_done     = done_q;
    assign lock_lost    = lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes with their
// edge numbers; a monitor pops and compares whenever the outputs change.
module tb_reset_sequencer;

    localparam int unsigned N = 3;
    localparam int unsigned D = 4;
    localparam int unsigned L = 8;

    logic         clk;
    logic         resetn;
    logic         pll_locked;
    logic [N-1:0] stage_resetn;
    logic         seq_done;
    logic         lock_lost;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       done;
        logic       lost;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    reset_sequencer #(
        .NUM_STAGES        (N),
        .STAGE_DELAY       (D),
        .LOCK_STABLE_CYCLES(L)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pll_locked  (pll_locked),
        .stage_resetn(stage_resetn),
        .seq_done    (seq_done),
        .lock_lost   (lock_lost)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, want, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] st, input logic d, input logic l);
        exp_t e;
        e.cyc  = c;
        e.st   = st;
        e.done = d;
        e.lost = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on any output change
    initial begin
        logic [4:0] prev, cur;
        logic       prev_lost;
        logic [2:0] inc;
        exp_t       e;
        prev      = '0;
        prev_lost = 1'b0;
        forever begin
            @(negedge clk);
            cur = {stage_resetn, seq_done, lock_lost};
            inc = stage_resetn + 3'd1;
            check("thermometer", 32'((stage_resetn & inc) == 3'd0), 32'd1);
            check("seq_done_vs_stages", 32'(seq_done), 32'(stage_resetn == 3'b111));
            check("lock_lost_two_cycles", 32'(prev_lost & lock_lost), 32'd0);
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_change: outputs=%b at cyc=%0d", cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                    check("event_stage_resetn", 32'(stage_resetn), 32'(e.st));
                    check("event_seq_done", 32'(seq_done), 32'(e.done));
                    check("event_lock_lost", 32'(lock_lost), 32'(e.lost));
                end
            end
            prev      = cur;
            prev_lost = lock_lost;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, m, p, q, r, s, n5;
        resetn     = 1'b0;
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values with lock already high
        check("reset_stage_resetn", 32'(stage_resetn), 32'd0);
        check("reset_seq_done", 32'(seq_done), 32'd0);
        check("reset_lock_lost", 32'(lock_lost), 32'd0);

        // Nominal: E0 = n0+10, releases every D+1 edges
        n0 = cyc;
        push(n0 + 15, 3'b001, 1'b0, 1'b0);
        push(n0 + 20, 3'b011, 1'b0, 1'b0);
        push(n0 + 25, 3'b111, 1'b1, 1'b0);
        resetn = 1'b1;
        wait_until(n0 + 27);

        // Lock loss in DONE, then re-qualify
        m = cyc;
        push(m + 3, 3'b000, 1'b0, 1'b1);
        push(m + 4, 3'b000, 1'b0, 1'b0);
        pll_locked = 1'b0;
        wait_until(m + 4);
        p = cyc;
        push(p + 15, 3'b001, 1'b0, 1'b0);
        push(p + 20, 3'b011, 1'b0, 1'b0);
        push(p + 25, 3'b111, 1'b1, 1'b0);
        pll_locked = 1'b1;
        wait_until(p + 27);

        // Lock loss on the very edge stage 1 is due
        q = cyc;
        push(q + 3, 3'b000, 1'b0, 1'b1);
        push(q + 4, 3'b000, 1'b0, 1'b0);
        pll_locked = 1'b0;
        wait_until(q + 4);
        r = cyc;
        push(r + 15, 3'b001, 1'b0, 1'b0);
        push(r + 20, 3'b000, 1'b0, 1'b1);
        push(r + 21, 3'b000, 1'b0, 1'b0);
        pll_locked = 1'b1;
        wait_until(r + 17);
        pll_locked = 1'b0;
        wait_until(r + 22);

        // Glitch during qualification: 6 high, 1 low, then high; count must restart
        s = cyc;
        push(s + 22, 3'b001, 1'b0, 1'b0);
        push(s + 24, 3'b000, 1'b0, 1'b0);
        pll_locked = 1'b1;
        wait_until(s + 6);
        pll_locked = 1'b0;
        wait_until(s + 7);
        pll_locked = 1'b1;
        wait_until(s + 23);

        // Asynchronous reset mid-RELEASE clears outputs before any clock edge
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_stage_resetn", 32'(stage_resetn), 32'd0);
        check("async_reset_seq_done", 32'(seq_done), 32'd0);
        check("async_reset_lock_lost", 32'(lock_lost), 32'd0);
        wait_until(s + 27);

        // Nominal sequence again out of reset
        n5 = cyc;
        push(n5 + 15, 3'b001, 1'b0, 1'b0);
        push(n5 + 20, 3'b011, 1'b0, 1'b0);
        push(n5 + 25, 3'b111, 1'b1, 1'b0);
        resetn = 1'b1;
        wait_until(n5 + 27);

        check("pending_expected_events", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
